hucbus_arbiter: RTL and testbench

//  Shares the single 21-bit physical memory port between the HuC6280 core and one

---
 rtl/hucbus_pkg.sv | 24 ++
 rtl/sat_counter.sv | 31 +++
 rtl/hucbus_arbiter.sv | 129 ++++++++++++
 tb/tb_hucbus_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hucbus_pkg.sv
// hucbus_pkg: shared types, default widths and a counter-width helper for the HuC bus arbiter.
package hucbus_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Bits needed to count 0..max-1; a single bit when max is 1.
  function automatic int cnt_width(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: clock-enabled up counter that sticks at MAX-1; clear has priority over increment.
module sat_counter
  import hucbus_pkg::*;
#(
  parameter int  MAX = 8,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clk_en,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] TOP = W'(MAX - 1);

  // Count enabled increments, hold at TOP, and drop to zero on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clk_en) begin
      if (clear) begin
        count <= '0;
      end else if (inc && (count != TOP)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hucbus_arbiter.sv
// hucbus_arbiter: shares the single physical memory port between the HuC6280 core and a
// DMA requester. The CPU owns the bus by default; DMA takes it on CPU idle cycles or after
// a bounded wait, and gives it back at burst end, on request drop, or after a capped tenure
// while the CPU is waiting. Address/data widths come from hucbus_pkg.
module hucbus_arbiter
  import hucbus_pkg::*;
#(
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_rdy_n,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int WAIT_W  = cnt_width(MAX_WAIT);
  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam logic [WAIT_W-1:0]  WAIT_TOP  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BURST_TOP = BURST_W'(MAX_BURST - 1);

  owner_t owner, owner_nxt;
  logic   cpu_active, beat, take_bus, give_bus;
  logic   wait_full, burst_full;
  logic   [WAIT_W-1:0]  wait_cnt;
  logic   [BURST_W-1:0] burst_cnt;
  bus_req_t sel;

  assign cpu_active = cpu_re | cpu_we;
  assign beat       = (owner == OWN_DMA) & dma_req;
  assign wait_full  = (wait_cnt == WAIT_TOP);
  assign burst_full = (burst_cnt == BURST_TOP);

  // Consecutive denied DMA request cycles while the CPU keeps the bus.
  sat_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .clear   (take_bus | ~dma_req | (owner == OWN_DMA)),
    .inc     ((owner == OWN_CPU) & dma_req),
    .count   (wait_cnt)
  );

  // Beats granted in the current DMA tenure; sticks at the cap while the CPU is idle.
  sat_counter #(.MAX(MAX_BURST)) u_burst_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .clear   ((owner == OWN_CPU) | give_bus),
    .inc     (beat),
    .count   (burst_cnt)
  );

  // Owner register; only advances on enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner <= OWN_CPU;
    end else if (clk_en) begin
      owner <= owner_nxt;
    end
  end

  // Ownership transfer decisions: DMA takes over on idle or starved, hands back on end/cap/drop.
  always_comb begin
    owner_nxt = owner;
    take_bus  = 1'b0;
    give_bus  = 1'b0;
    case (owner)
      OWN_CPU: begin
        if (dma_req && (!cpu_active || wait_full)) begin
          take_bus  = 1'b1;
          owner_nxt = OWN_DMA;
        end
      end
      OWN_DMA: begin
        if (!dma_req || (beat && dma_last) || (beat && burst_full && cpu_active)) begin
          give_bus  = 1'b1;
          owner_nxt = OWN_CPU;
        end
      end
      default: owner_nxt = OWN_CPU;
    endcase
  end

  // Memory port mux: CPU fields by default, DMA fields gated by its request while it owns the bus.
  always_comb begin
    sel = '{addr: cpu_addr, re: cpu_re, we: cpu_we, wdata: cpu_dout};
    if (owner == OWN_DMA) begin
      sel = '{addr: dma_addr, re: dma_req & ~dma_we, we: dma_req & dma_we, wdata: dma_wdata};
    end
  end

  // Read-data valid for the DMA lines up with the one-cycle memory read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_rvalid <= 1'b0;
    end else if (clk_en) begin
      dma_rvalid <= beat & ~dma_we;
    end
  end

  assign mem_addr  = sel.addr;
  assign mem_re    = sel.re;
  assign mem_we    = sel.we;
  assign mem_din   = sel.wdata;
  assign cpu_din   = mem_dout;
  assign dma_rdata = mem_dout;
  assign cpu_rdy_n = (owner == OWN_DMA);
  assign dma_gnt   = beat;

endmodule

// File: tb/tb_hucbus_arbiter.sv
// tb_hucbus_arbiter: randomized traffic against a transaction-level arbitration model,
// plus directed checks for reset, forced grants, burst caps, DMA reads and clock enable.
`timescale 1ns/1ps
module tb_hucbus_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int MAX_BURST = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_dout = '0, cpu_din;
  logic        cpu_rdy_n;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [20:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0, dma_rdata;
  logic        dma_gnt, dma_rvalid;
  logic [20:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hucbus_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_rdy_n(cpu_rdy_n),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Bench memory: sparse byte store with one-cycle registered read.
  logic [7:0] mem [int];
  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (mem_re) mem_dout <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : init_val(int'(mem_addr));
    if (mem_we) mem[int'(mem_addr)] = mem_din;
  end

  // Reference model state: who owns the bus, how long DMA has waited, beats this tenure.
  bit         m_dma;
  int         m_wait, m_burst;
  logic       m_rvalid;
  logic [7:0] m_dout;
  logic [7:0] ref_mem [int];
  logic       e_gnt, e_rdyn, e_re, e_we;
  logic [20:0] e_addr;
  logic [7:0]  e_din;

  int         mis_cnt, mis_first, gnt_cnt, first_gnt;
  logic       gnt_hist [512];
  logic       rdy_hist [512];
  logic [7:0] wlog [64];

  task automatic model_reset();
    m_dma = 0; m_wait = 0; m_burst = 0; m_rvalid = 1'b0;
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    mem[a] = v; ref_mem[a] = v;
  endtask

  // What the port should show right now given who owns it.
  task automatic model_eval();
    e_rdyn = m_dma;
    e_gnt  = m_dma && dma_req;
    if (m_dma) begin
      e_addr = dma_addr; e_re = dma_req && !dma_we; e_we = dma_req && dma_we; e_din = dma_wdata;
    end else begin
      e_addr = cpu_addr; e_re = cpu_re; e_we = cpu_we; e_din = cpu_dout;
    end
  endtask

  // Apply one clock edge to the model using the inputs that were present before it.
  task automatic model_edge();
    bit busy, done;
    int a;
    a = int'(e_addr);
    if (e_re) m_dout = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    if (e_we) ref_mem[a] = e_din;
    if (clk_en) begin
      busy = cpu_re || cpu_we;
      m_rvalid = e_gnt && !dma_we;
      if (!m_dma) begin
        if (dma_req && (!busy || m_wait >= MAX_WAIT - 1)) begin
          m_dma = 1; m_wait = 0;
        end else if (dma_req) begin
          m_wait = (m_wait + 1 > MAX_WAIT - 1) ? MAX_WAIT - 1 : m_wait + 1;
        end else begin
          m_wait = 0;
        end
      end else begin
        done = !dma_req || (e_gnt && dma_last) || (e_gnt && busy && m_burst == MAX_BURST - 1);
        if (done) begin
          m_dma = 0; m_burst = 0;
        end else if (e_gnt) begin
          m_burst = (m_burst + 1 > MAX_BURST - 1) ? MAX_BURST - 1 : m_burst + 1;
        end
      end
    end
  endtask

  // Drive CPU and DMA traffic cycle by cycle, tracking model agreement and grant history.
  task automatic run_traffic(input int beats, input logic we, input logic [20:0] base,
                             input int cpu_mode, input int en_pct, input int freeze,
                             input int stop_beats, input int max_cycles);
    int beat, c, limit;
    beat = 0; c = 0;
    limit = (stop_beats < beats) ? stop_beats : beats;
    mis_cnt = 0; mis_first = 0; gnt_cnt = 0; first_gnt = 0;
    for (int k = 0; k < 512; k++) begin gnt_hist[k] = 1'b0; rdy_hist[k] = 1'b0; end
    for (int k = 0; k < 64; k++) wlog[k] = 8'($urandom);
    while (c < max_cycles && !(beats > 0 && beat >= limit)) begin
      c++;
      clk_en = (c <= freeze) ? 1'b0 : (int'($urandom_range(99)) < en_pct);
      case (cpu_mode)
        1: begin cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h1FE000; end
        2: begin
          cpu_re = ($urandom_range(2) == 0);
          cpu_we = !cpu_re && ($urandom_range(1) == 0);
          cpu_addr = 21'h1FE000 + 21'($urandom_range(15));
        end
        default: begin cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 21'($urandom); end
      endcase
      cpu_dout  = 8'($urandom);
      dma_req   = (beat < beats);
      dma_addr  = base + 21'(beat);
      dma_we    = we;
      dma_wdata = wlog[beat % 64];
      dma_last  = (beat == beats - 1);
      #1;
      model_eval();
      if (dma_gnt !== e_gnt || cpu_rdy_n !== e_rdyn || mem_addr !== e_addr || mem_re !== e_re ||
          mem_we !== e_we || mem_din !== e_din || dma_rvalid !== m_rvalid ||
          dma_rdata !== m_dout || cpu_din !== m_dout) begin
        mis_cnt++;
        if (mis_first == 0) mis_first = c;
      end
      if (c < 512) begin gnt_hist[c] = dma_gnt; rdy_hist[c] = cpu_rdy_n; end
      if (dma_gnt === 1'b1 && first_gnt == 0) first_gnt = c;
      @(posedge clk);
      model_edge();
      if (e_gnt && clk_en) begin beat++; gnt_cnt++; end
      #1;
    end
  endtask

  task automatic settle();
    run_traffic(0, 1'b0, 21'h0, 0, 100, 0, 0, 3);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (cpu_rdy_n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rdy_n: got %b expected 0", cpu_rdy_n); end
    n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 0", dma_gnt); end
    n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b expected 0", dma_rvalid); end
    model_reset();
    m_dout = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_cpu_only();
    int busy_seen;
    run_traffic(0, 1'b0, 21'h0, 1, 100, 0, 0, 6);
    busy_seen = 0;
    for (int k = 1; k <= 6; k++) if (rdy_hist[k] !== 1'b0 || gnt_hist[k] !== 1'b0) busy_seen++;
    n_checks++; if (mis_cnt !== 0) begin n_fail++; $display("[TB] FAIL cpu_only_trace: %0d bad cycles (first %0d) expected 0", mis_cnt, mis_first); end
    n_checks++; if (busy_seen !== 0) begin n_fail++; $display("[TB] FAIL cpu_only_hold: %0d cycles with rdy_n/gnt high expected 0", busy_seen); end
    n_checks++; if (mem_addr !== 21'h1FE000) begin n_fail++; $display("[TB] FAIL cpu_only_addr: got %h expected 1fe000", mem_addr); end
    n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("[TB] FAIL cpu_only_re: got %b expected 1", mem_re); end
  endtask

  task automatic test_dma_idle_burst();
    int bad_data;
    run_traffic(4, 1'b1, 21'h000020, 0, 100, 0, 99, 20);
    dma_req = 1'b0;
    #1;
    n_checks++; if (mis_cnt !== 0) begin n_fail++; $display("[TB] FAIL idle_burst_trace: %0d bad cycles (first %0d) expected 0", mis_cnt, mis_first); end
    n_checks++; if (gnt_cnt !== 4) begin n_fail++; $display("[TB] FAIL idle_burst_beats: got %0d expected 4", gnt_cnt); end
    n_checks++; if (first_gnt !== 2) begin n_fail++; $display("[TB] FAIL idle_burst_first_gnt: got cycle %0d expected 2", first_gnt); end
    n_checks++; if (cpu_rdy_n !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_burst_release: rdy_n %b expected 0", cpu_rdy_n); end
    bad_data = 0;
    for (int k = 0; k < 4; k++) if (!mem.exists(32 + k) || mem[32 + k] !== wlog[k]) bad_data++;
    n_checks++; if (bad_data !== 0) begin n_fail++; $display("[TB] FAIL idle_burst_data: %0d bytes wrong expected 0", bad_data); end
    settle();
  endtask

  task automatic test_forced_wait();
    run_traffic(4, 1'b0, 21'h000100, 1, 100, 0, 99, 40);
    n_checks++; if (mis_cnt !== 0) begin n_fail++; $display("[TB] FAIL forced_trace: %0d bad cycles (first %0d) expected 0", mis_cnt, mis_first); end
    n_checks++; if (first_gnt !== 9) begin n_fail++; $display("[TB] FAIL forced_first_gnt: got cycle %0d expected 9", first_gnt); end
    n_checks++; if (rdy_hist[8] !== 1'b0 || rdy_hist[9] !== 1'b1) begin n_fail++; $display("[TB] FAIL forced_rdy_n: c8=%b c9=%b expected 0/1", rdy_hist[8], rdy_hist[9]); end
    settle();
  endtask

  task automatic test_burst_limit();
    int first_cnt, regrant;
    run_traffic(40, 1'b1, 21'h000200, 1, 100, 0, 99, 200);
    first_cnt = 0;
    for (int k = 9; k <= 24; k++) if (gnt_hist[k] === 1'b1) first_cnt++;
    regrant = 0;
    for (int k = 25; k < 60 && regrant == 0; k++) if (gnt_hist[k] === 1'b1) regrant = k;
    n_checks++; if (mis_cnt !== 0) begin n_fail++; $display("[TB] FAIL burst_trace: %0d bad cycles (first %0d) expected 0", mis_cnt, mis_first); end
    n_checks++; if (first_cnt !== 16) begin n_fail++; $display("[TB] FAIL burst_first_tenure: got %0d beats expected 16", first_cnt); end
    n_checks++; if (rdy_hist[25] !== 1'b0) begin n_fail++; $display("[TB] FAIL burst_release: rdy_n at c25 %b expected 0", rdy_hist[25]); end
    n_checks++; if (regrant !== 33) begin n_fail++; $display("[TB] FAIL burst_regrant: got cycle %0d expected 33", regrant); end
    n_checks++; if (gnt_cnt !== 40) begin n_fail++; $display("[TB] FAIL burst_total: got %0d beats expected 40", gnt_cnt); end
    settle();
  endtask

  task automatic test_dma_read();
    preload(32'h21, 8'h5A);
    run_traffic(1, 1'b0, 21'h000021, 0, 100, 0, 99, 10);
    n_checks++; if (first_gnt !== 2) begin n_fail++; $display("[TB] FAIL read_gnt: got cycle %0d expected 2", first_gnt); end
    n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL read_rvalid: got %b expected 1", dma_rvalid); end
    n_checks++; if (dma_rdata !== 8'h5A) begin n_fail++; $display("[TB] FAIL read_rdata: got %h expected 5a", dma_rdata); end
    n_checks++; if (mis_cnt !== 0) begin n_fail++; $display("[TB] FAIL read_trace: %0d bad cycles (first %0d) expected 0", mis_cnt, mis_first); end
    settle();
  endtask

  task automatic test_reset_mid_burst();
    run_traffic(8, 1'b0, 21'h000300, 0, 100, 0, 3, 20);
    n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_pre_rvalid: got %b expected 1", dma_rvalid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (cpu_rdy_n !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_rdy_n: got %b expected 0", cpu_rdy_n); end
    n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_rvalid: got %b expected 0", dma_rvalid); end
    n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_gnt: got %b expected 0", dma_gnt); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run_traffic(4, 1'b1, 21'h000400, 1, 100, 5, 99, 40);
    n_checks++; if (first_gnt !== 14) begin n_fail++; $display("[TB] FAIL freeze_first_gnt: got cycle %0d expected 14", first_gnt); end
    n_checks++; if (mis_cnt !== 0) begin n_fail++; $display("[TB] FAIL freeze_trace: %0d bad cycles (first %0d) expected 0", mis_cnt, mis_first); end
    settle();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      run_traffic(30, 1'($urandom_range(1)), 21'($urandom_range(21'h1FFF00)), 2, 70, 0, 99, 400);
      n_checks++; if (mis_cnt !== 0) begin n_fail++; $display("[TB] FAIL random_trace[%0d]: %0d bad cycles (first %0d) expected 0", r, mis_cnt, mis_first); end
      n_checks++; if (gnt_cnt !== 30) begin n_fail++; $display("[TB] FAIL random_beats[%0d]: got %0d expected 30", r, gnt_cnt); end
      settle();
    end
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_dma_idle_burst();
    test_forced_wait();
    test_burst_limit();
    test_dma_read();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
